// File: rtl/vector_stim_checker.sv
// vector_stim_checker
//
// Stimulus generator and response checker for a small combinational DUT.
// It drives every input vector in ascending order, holds each one for
// SETTLE_CYC+1 cycles, and then compares the DUT output against EXP_TABLE.
// It reports an error count and the index of the first failing vector.
//
// Optional feature (compile-time macro VECTOR_STOP_ON_FAIL_EN):
//   When the macro is defined, the run ends at the first mismatch. dut_in then
//   holds the failing vector and err_cnt is 1.
//   When the macro is undefined, every vector is always applied.
//
// Ports:
//   clk              rising-edge clock
//   rst_n            synchronous active-low reset
//   start            run request, accepted only in IDLE or DONE
//   dut_y            DUT output under test
//   dut_in           vector driven to the DUT (MSB = DUT input a)
//   busy             high while a run is in progress
//   done             high from run completion until the next accepted start or reset
//   pass             done and no mismatches
//   err_cnt          mismatch count, saturating at 2**N_IN
//   first_fail_valid a mismatch has been recorded in this run
//   first_fail_vec   vector index of the first mismatch

module vector_stim_checker #(
    parameter int unsigned        N_IN       = 3,
    parameter int unsigned        SETTLE_CYC = 1,
    parameter logic [2**N_IN-1:0] EXP_TABLE  = 8'hFF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            dut_y,
    output logic [N_IN-1:0] dut_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_vec
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [3:0]      SettleLim = 4'(SETTLE_CYC);
    localparam logic [N_IN:0]   ErrMax    = {1'b1, {N_IN{1'b0}}};
    localparam logic [N_IN-1:0] VecMax    = {N_IN{1'b1}};

    state_e          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [3:0]      hc_q, hc_d;
    logic [N_IN:0]   err_q, err_d;
    logic            ffv_q, ffv_d;
    logic [N_IN-1:0] ffvec_q, ffvec_d;
    logic            mismatch;
    logic            stop;

    // Case inequality, so an X or Z on dut_y counts as a mismatch in simulation.
    assign mismatch = (dut_y !== EXP_TABLE[vec_q]);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        hc_d    = hc_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffvec_d = ffvec_q;
        stop    = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    vec_d   = '0;
                    hc_d    = '0;
                    err_d   = '0;
                    ffv_d   = 1'b0;
                end
            end
            StRun: begin
                if (hc_q != SettleLim) begin
                    hc_d = hc_q + 4'd1;
                end else begin
                    // Sample edge for the current vector.
                    if (mismatch) begin
                        if (err_q != ErrMax) begin
                            err_d = err_q + 1'b1;
                        end
                        if (!ffv_q) begin
                            ffv_d   = 1'b1;
                            ffvec_d = vec_q;
                        end
`ifdef VECTOR_STOP_ON_FAIL_EN
                        stop = 1'b1;
`else
                        stop = 1'b0;
`endif
                    end
                    if (stop || vec_q == VecMax) begin
                        // dut_in keeps the last applied vector.
                        state_d = StDone;
                    end else begin
                        vec_d = vec_q + 1'b1;
                        hc_d  = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            vec_q   <= '0;
            hc_q    <= '0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hc_q    <= hc_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
        end
    end

    assign dut_in           = vec_q;
    assign busy             = (state_q == StRun);
    assign done             = (state_q == StDone);
    assign pass             = done && (err_q == '0);
    assign err_cnt          = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_vector_stim_checker.sv
// tb_vector_stim_checker
//
// Directed bench for vector_stim_checker.
// Instance u_dut uses the default parameters and a behavioural DUT selected by
// `mode`. Instance u_xor uses N_IN=2 and SETTLE_CYC=0 and checks an XOR gate.
// Expected values follow the VECTOR_STOP_ON_FAIL_EN setting.

module tb_vector_stim_checker;

    logic       clk = 1'b0;
    logic       rst_n, start, dut_y;
    logic [2:0] dut_in;
    logic       busy, done, pass, ffv;
    logic [3:0] err_cnt;
    logic [2:0] ffvec;

    logic       rst_n2, start2, dut_y2;
    logic [1:0] dut_in2;
    logic       busy2, done2, pass2, ffv2;
    logic [2:0] err_cnt2;
    logic [1:0] ffvec2;

    int checks = 0;
    int errors = 0;
    int mode   = 0;

    always #5 clk = ~clk;

    // 0: y=1 always, 1: stuck-at-0, 2: y=0 only for vector 5
    always_comb begin
        case (mode)
            1:       dut_y = 1'b0;
            2:       dut_y = (dut_in != 3'd5);
            default: dut_y = 1'b1;
        endcase
    end

    assign dut_y2 = ^dut_in2;

    vector_stim_checker u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .dut_y            (dut_y),
        .dut_in           (dut_in),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_cnt          (err_cnt),
        .first_fail_valid (ffv),
        .first_fail_vec   (ffvec)
    );

    vector_stim_checker #(
        .N_IN       (2),
        .SETTLE_CYC (0),
        .EXP_TABLE  (4'b0110)
    ) u_xor (
        .clk              (clk),
        .rst_n            (rst_n2),
        .start            (start2),
        .dut_y            (dut_y2),
        .dut_in           (dut_in2),
        .busy             (busy2),
        .done             (done2),
        .pass             (pass2),
        .err_cnt          (err_cnt2),
        .first_fail_valid (ffv2),
        .first_fail_vec   (ffvec2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a run and counts the edges from the start edge until done rises.
    // A start pulse is injected at edge repulse_at. cycles stays 0 on timeout.
    task automatic run1(input int repulse_at, output int cycles, output logic [47:0] seq);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_init", {busy, done, err_cnt, ffv, dut_in}, {1'b1, 1'b0, 4'd0, 1'b0, 3'd0});
        cycles = 0;
        seq    = '0;
        for (int k = 1; k <= 100; k++) begin
            start = (k == repulse_at);
            tick();
            start = 1'b0;
            if (k <= 16) seq[3*(k-1) +: 3] = dut_in;
            if (done) begin
                cycles = k;
                break;
            end
        end
    endtask

    initial begin
        int          cyc;
        logic [47:0] seq, exp_seq;

        rst_n  = 1'b0;
        start  = 1'b0;
        rst_n2 = 1'b0;
        start2 = 1'b0;
        tick();
        tick();
        check("reset_state", {busy, done, pass, err_cnt, ffv, ffvec, dut_in}, 64'd0);
        rst_n  = 1'b1;
        rst_n2 = 1'b1;
        tick();

        // All-correct DUT.
        mode = 0;
        run1(0, cyc, seq);
        for (int k = 1; k <= 16; k++) begin
            exp_seq[3*(k-1) +: 3] = (k >= 16) ? 3'd7 : 3'(k / 2);
        end
        check("good_cycles", cyc, 16);
        check("good_pass", {pass, err_cnt, ffv, busy}, {1'b1, 4'd0, 1'b0, 1'b0});
        check("good_seq", seq, exp_seq);

        // Stuck-at-0 DUT. This run also covers a start accepted in DONE.
        mode = 1;
        run1(0, cyc, seq);
`ifdef VECTOR_STOP_ON_FAIL_EN
        check("stuck_cycles", cyc, 2);
        check("stuck_err", err_cnt, 1);
        check("stuck_dut_in", dut_in, 0);
`else
        check("stuck_cycles", cyc, 16);
        check("stuck_err", err_cnt, 8);
        check("stuck_dut_in", dut_in, 7);
`endif
        check("stuck_ff", {pass, ffv, ffvec}, {1'b0, 1'b1, 3'd0});

        // Single failing vector (5).
        mode = 2;
        run1(0, cyc, seq);
`ifdef VECTOR_STOP_ON_FAIL_EN
        check("v5_cycles", cyc, 12);
        check("v5_dut_in", dut_in, 5);
`else
        check("v5_cycles", cyc, 16);
        check("v5_dut_in", dut_in, 7);
`endif
        check("v5_err", {pass, err_cnt, ffv, ffvec}, {1'b0, 4'd1, 1'b1, 3'd5});

        // Restart from DONE clears err_cnt; a start pulse while busy is ignored.
        mode = 0;
        run1(5, cyc, seq);
        check("repulse_cycles", cyc, 16);
        check("repulse_pass", {pass, err_cnt}, {1'b1, 4'd0});

        // Reset held low for the edge at cycle 7 of a run.
        run1(-1, cyc, seq);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrun_reset", {busy, done, pass, err_cnt, ffv, ffvec, dut_in}, 64'd0);
        for (int k = 0; k < 5; k++) tick();
        check("idle_quiet", {busy, done, dut_in}, 64'd0);

        // Reset takes priority over a simultaneous start.
        start = 1'b1;
        rst_n = 1'b0;
        tick();
        start = 1'b0;
        rst_n = 1'b1;
        check("reset_wins", {busy, done}, 64'd0);

        // XOR instance with N_IN=2 and SETTLE_CYC=0.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (done2) begin
                cyc = k;
                break;
            end
        end
        check("xor_cycles", cyc, 4);
        check("xor_pass", {pass2, err_cnt2, ffv2, dut_in2}, {1'b1, 3'd0, 1'b0, 2'd3});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
